// File: rtl/seg_pkg.sv
// seg_pkg: char codes, active-low glyph table and shared types for the 7-segment scan driver
package seg_pkg;
  localparam int SLOT_W = 2;
  typedef enum logic [5:0] {
    CH_0, CH_1, CH_2, CH_3, CH_4, CH_5, CH_6, CH_7, CH_8, CH_9,
    CH_A, CH_B, CH_C, CH_D, CH_E, CH_F, CH_G, CH_H, CH_I, CH_J, CH_K, CH_L, CH_M,
    CH_N, CH_O, CH_P, CH_Q, CH_R, CH_S, CH_T, CH_U, CH_V, CH_W, CH_X, CH_Y, CH_Z,
    CH_BLANK = 6'd63
  } char_t;
  typedef struct packed {
    logic              v;
    logic [SLOT_W-1:0] idx;
  } cap_t;
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [6:0] SEG_0 = 7'h40, SEG_1 = 7'h79, SEG_2 = 7'h24, SEG_3 = 7'h30, SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12, SEG_6 = 7'h02, SEG_7 = 7'h78, SEG_8 = 7'h00, SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08, SEG_B = 7'h03, SEG_C = 7'h46, SEG_D = 7'h21, SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E, SEG_G = 7'h42, SEG_H = 7'h09, SEG_I = 7'h79, SEG_J = 7'h61;
  localparam logic [6:0] SEG_K = 7'h0A, SEG_L = 7'h47, SEG_N = 7'h2B, SEG_O = 7'h23, SEG_P = 7'h0C;
  localparam logic [6:0] SEG_Q = 7'h18, SEG_R = 7'h2F, SEG_S = 7'h12, SEG_T = 7'h07, SEG_U = 7'h41;
  localparam logic [6:0] SEG_V = 7'h63, SEG_Y = 7'h11, SEG_Z = 7'h24;
  localparam logic [6:0] SEG_M = SEG_N, SEG_W = SEG_U, SEG_X = SEG_H;
  localparam logic [36*7-1:0] GLYPHS = {
    SEG_Z, SEG_Y, SEG_X, SEG_W, SEG_V, SEG_U, SEG_T, SEG_S, SEG_R, SEG_Q, SEG_P, SEG_O, SEG_N,
    SEG_M, SEG_L, SEG_K, SEG_J, SEG_I, SEG_H, SEG_G, SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A,
    SEG_9, SEG_8, SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
  };
endpackage

// File: rtl/seg_scan_driver_char_to_seg.sv
// char_to_seg: combinational 6-bit char code to active-low {g,f,e,d,c,b,a} glyph
module char_to_seg
  import seg_pkg::*;
(
  input  logic [5:0] code,
  output logic [6:0] seg
);
  assign seg = (code <= CH_Z) ? GLYPHS[code*7 +: 7] : SEG_OFF;
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: 4-digit multiplexed 7-seg scan, slot strobe, frame capture; SEG_BLINK_EN adds blink
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int CAP_LAT  = 2
) (
  input  logic              clk,
  input  logic              rst,
`ifdef SEG_BLINK_EN
  input  logic              blink,
`endif
  input  logic [5:0]        message,
  output logic              ref_sign,
  output logic [SLOT_W-1:0] refresh,
  output logic [3:0]        an,
  output logic [6:0]        seg,
  output logic              dp
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] LAST = DW'(SCAN_DIV - 1);
  logic [DW-1:0] div_cnt;
  cap_t          pipe [CAP_LAT];
  logic [5:0]    frame [4];
  logic [3:0]    an_q;
  logic [6:0]    glyph;
  char_to_seg u_c2s (.code(frame[refresh]), .seg(glyph));
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt  <= '0;
      refresh  <= '0;
      ref_sign <= 1'b0;
      frame    <= '{default: CH_BLANK};
      an_q     <= 4'hF;
      seg      <= SEG_OFF;
      for (int i = 0; i < CAP_LAT; i++) pipe[i] <= '0;
    end else begin
      div_cnt  <= (div_cnt == LAST) ? '0 : div_cnt + 1'b1;
      ref_sign <= div_cnt == LAST;
      if (div_cnt == LAST) refresh <= refresh + 1'b1;
      pipe[0] <= '{v: ref_sign, idx: refresh};
      for (int i = 1; i < CAP_LAT; i++) pipe[i] <= pipe[i-1];
      if (pipe[CAP_LAT-1].v) frame[pipe[CAP_LAT-1].idx] <= message;
      an_q <= ~(4'b0001 << refresh);
      seg  <= glyph;
    end
  end
  assign dp = 1'b1;
`ifdef SEG_BLINK_EN
  logic [23:0] blink_cnt;
  always_ff @(posedge clk) blink_cnt <= rst ? '0 : blink_cnt + 1'b1;
  assign an = an_q | {4{blink & blink_cnt[23]}};
`else
  assign an = an_q;
`endif
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: three latencies (2,1,4) checked each cycle against an arithmetic slot/frame model
module tb_seg_scan_driver;
  localparam int SD = 8;
  localparam int LAT [3] = '{2, 1, 4};
  localparam logic [6:0] HI [36] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F,
    7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71, 7'h3D, 7'h76, 7'h06, 7'h1E, 7'h75, 7'h38, 7'h54,
    7'h54, 7'h5C, 7'h73, 7'h67, 7'h50, 7'h6D, 7'h78, 7'h3E, 7'h1C, 7'h3E, 7'h76, 7'h6E, 7'h5B
  };
  localparam int NIOC [4] = '{23, 18, 24, 12};
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] msg [3];
  logic       rs  [3];
  logic [1:0] rf  [3];
  logic [3:0] an  [3];
  logic [6:0] seg [3];
  logic       dp  [3];
  int n, checks, fails;
  bit directed;
  int mh [3][0:1023];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    seg_scan_driver #(.SCAN_DIV(SD), .CAP_LAT(g == 0 ? 2 : g == 1 ? 1 : 4)) dut (
      .clk(clk),
      .rst(rst),
`ifdef SEG_BLINK_EN
      .blink(1'b0),
`endif
      .message(msg[g]),
      .ref_sign(rs[g]),
      .refresh(rf[g]),
      .an(an[g]),
      .seg(seg[g]),
      .dp(dp[g])
    );
  end
  function automatic logic [6:0] glyph(int c);
    return (c < 36) ? ~HI[c] : 7'h7F;
  endfunction
  function automatic int frame_at(int g, int m, int s);
    int v = 63;
    for (int k = 1; SD*k + LAT[g] + 1 <= m; k++)
      if (k % 4 == s) v = mh[g][SD*k + LAT[g]];
    return v;
  endfunction
  task automatic chk(string tag, int g, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s dut%0d n=%0d observed=%0h expected=%0h", tag, g, n, obs, exp);
    end
  endtask
  task automatic check_all();
    for (int g = 0; g < 3; g++) begin
      int rp = (n > 0) ? ((n - 1) / SD) % 4 : 0;
      logic [3:0] ea = (n > 0) ? 4'hF & ~(4'b0001 << rp) : 4'hF;
      logic [6:0] es = (n > 0) ? glyph(frame_at(g, n - 1, rp)) : 7'h7F;
      chk("ref_sign", g, 32'(rs[g]), 32'(n > 0 && n % SD == 0));
      chk("refresh", g, 32'(rf[g]), 32'((n / SD) % 4));
      chk("an", g, 32'(an[g]), 32'(ea));
      chk("seg", g, 32'(seg[g]), 32'(es));
      chk("dp", g, 32'(dp[g]), 32'd1);
    end
  endtask
  task automatic drive();
    for (int g = 0; g < 3; g++) begin
      int v = int'($urandom_range(0, 63));
      if (directed && n >= SD + LAT[g] && (n - LAT[g]) % SD == 0) v = NIOC[((n - LAT[g]) / SD) % 4];
      mh[g][n] = v;
      msg[g] = v[5:0];
    end
  endtask
  task automatic do_reset(int c);
    rst = 1'b1;
    repeat (c) begin
      @(posedge clk);
      #1;
      n = 0;
      check_all();
    end
    rst = 1'b0;
    drive();
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    n++;
    check_all();
    drive();
  endtask
  initial begin
    for (int g = 0; g < 3; g++) msg[g] = '0;
    directed = 1'b1;
    do_reset(3);
    repeat (80) step();
    directed = 1'b0;
    repeat (3) step();
    while (n % SD != 0) step();
    do_reset(2);
    repeat (120) step();
    while (n % SD != 0) step();
    step();
    step();
    do_reset(1);
    repeat (100) step();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
